// File: rtl/anita4_l2_trigger_receiver_if.sv
// Bus bundle for the ANITA-4 TURF-side L2 trigger receiver.
// master = trigger/readout controller side, slave = receiver.
interface anita4_l2_trigger_receiver_if #(
    parameter int NUM_CH       = 4,
    parameter int SCALER_WIDTH = 16
);
    logic [NUM_CH-1:0]       trig_i;
    logic [NUM_CH-1:0]       mask_i;
    logic [NUM_CH-1:0]       l2_pulse_o;
    logic                    l3_o;
    logic [NUM_CH-1:0]       err_stuck_o;
    logic                    clear_err_i;
    logic                    scaler_latch_i;
    logic [1:0]              scaler_sel_i;
    logic [SCALER_WIDTH-1:0] scaler_o;
    logic [31:0]             l3_time_o;

    modport master (
        output trig_i, mask_i, clear_err_i, scaler_latch_i, scaler_sel_i,
        input  l2_pulse_o, l3_o, err_stuck_o, scaler_o, l3_time_o
    );

    modport slave (
        input  trig_i, mask_i, clear_err_i, scaler_latch_i, scaler_sel_i,
        output l2_pulse_o, l3_o, err_stuck_o, scaler_o, l3_time_o
    );
endinterface

// File: rtl/anita4_l2_trigger_receiver.sv
// SURF L2 line qualifier, L3 coincidence former and per-channel scalers.
// Define TRIG_TIMESTAMP_EN to timestamp each L3 with a free-running counter.
module anita4_l2_trigger_receiver #(
    parameter int NUM_CH       = 4,
    parameter int MIN_WIDTH    = 2,
    parameter int MAX_WIDTH    = 6,
    parameter int COINC_WINDOW = 3,
    parameter int SCALER_WIDTH = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    anita4_l2_trigger_receiver_if.slave  bus
);
    localparam int WW = $clog2(MAX_WIDTH + 2);
    localparam int CW = $clog2(COINC_WINDOW + 1);

    typedef enum logic [1:0] {IDLE, HIGH, STUCK} state_t;

    logic [NUM_CH-1:0]       sync1;
    logic [NUM_CH-1:0]       line;
    logic [NUM_CH-1:0]       accept;
    logic [NUM_CH-1:0]       l2;
    logic [NUM_CH-1:0]       err;
    logic [NUM_CH-1:0]       set_stuck;
    logic [NUM_CH-1:0]       inc;
    state_t                  st   [NUM_CH];
    logic [WW-1:0]           wcnt [NUM_CH];
    logic [CW-1:0]           win  [NUM_CH];
    logic [SCALER_WIDTH-1:0] cnt  [NUM_CH];
    logic [SCALER_WIDTH-1:0] lat  [NUM_CH];
    logic [7:0]              n_act;
    logic                    coinc_nx;
    logic                    coinc;
    logic                    l3;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1 <= '0;
            line  <= '0;
        end else begin
            sync1 <= bus.trig_i;
            line  <= sync1;
        end
    end

    always_comb begin
        set_stuck = '0;
        inc       = l2 & ~bus.mask_i;
        n_act     = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            set_stuck[c] = (st[c] == HIGH) && line[c] &&
                           (wcnt[c] == WW'(MAX_WIDTH));
            n_act = n_act + 8'((win[c] != '0) & ~bus.mask_i[c]);
        end
        coinc_nx = (n_act >= 8'd2);
    end

    // Width-qualifier FSM, one per line; wcnt counts synced-high cycles
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int c = 0; c < NUM_CH; c++) begin
                st[c]   <= IDLE;
                wcnt[c] <= '0;
            end
            accept <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                accept[c] <= 1'b0;
                unique case (st[c])
                    IDLE: begin
                        if (line[c]) begin
                            st[c]   <= HIGH;
                            wcnt[c] <= WW'(1);
                        end
                    end
                    HIGH: begin
                        if (line[c]) begin
                            wcnt[c] <= wcnt[c] + WW'(1);
                            if (set_stuck[c])
                                st[c] <= STUCK;
                        end else begin
                            accept[c] <= (wcnt[c] >= WW'(MIN_WIDTH)) &&
                                         (wcnt[c] <= WW'(MAX_WIDTH));
                            st[c]     <= IDLE;
                            wcnt[c]   <= '0;
                        end
                    end
                    STUCK: begin
                        if (!line[c]) begin
                            st[c]   <= IDLE;
                            wcnt[c] <= '0;
                        end
                    end
                    default: st[c] <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            l2    <= '0;
            err   <= '0;
            coinc <= 1'b0;
            l3    <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                win[c] <= '0;
                cnt[c] <= '0;
                lat[c] <= '0;
            end
        end else begin
            l2    <= accept;
            err   <= (err & ~{NUM_CH{bus.clear_err_i}}) | set_stuck;
            coinc <= coinc_nx;
            l3    <= coinc_nx & ~coinc;
            for (int c = 0; c < NUM_CH; c++) begin
                if (l2[c])
                    win[c] <= CW'(COINC_WINDOW);
                else if (win[c] != '0)
                    win[c] <= win[c] - CW'(1);
                // A pulse landing on the latch edge belongs to the new interval
                if (bus.scaler_latch_i) begin
                    lat[c] <= cnt[c];
                    cnt[c] <= SCALER_WIDTH'(inc[c]);
                end else if (inc[c] && (cnt[c] != '1)) begin
                    cnt[c] <= cnt[c] + SCALER_WIDTH'(1);
                end
            end
        end
    end

    always_comb begin
        bus.scaler_o = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (int'(bus.scaler_sel_i) == c)
                bus.scaler_o = lat[c];
    end

    assign bus.l2_pulse_o  = l2;
    assign bus.l3_o        = l3;
    assign bus.err_stuck_o = err;

`ifdef TRIG_TIMESTAMP_EN
    logic [31:0] ts;
    logic [31:0] l3_time;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ts      <= '0;
            l3_time <= '0;
        end else begin
            ts <= ts + 32'd1;
            if (coinc_nx & ~coinc)
                l3_time <= ts + 32'd1;
        end
    end

    assign bus.l3_time_o = l3_time;
`else
    assign bus.l3_time_o = '0;
`endif
endmodule

// File: tb/tb_anita4_l2_trigger_receiver.sv
// Directed bench for the L2 trigger receiver with an expected-pulse queue.
module tb_anita4_l2_trigger_receiver;
    localparam int MIN_W = 2;
    localparam int MAX_W = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int cyc = 0;
    logic [31:0] ts_m = '0;
    int q[$];
    int n_assert = 0;
    int n_fail = 0;
    int l3_cnt = 0;
    int l3_base;

    always #5 clk = ~clk;

    anita4_l2_trigger_receiver_if #(.NUM_CH(4), .SCALER_WIDTH(16)) bus();
    anita4_l2_trigger_receiver_if #(.NUM_CH(4), .SCALER_WIDTH(4)) bus_s();

    assign bus_s.trig_i         = bus.trig_i;
    assign bus_s.mask_i         = bus.mask_i;
    assign bus_s.clear_err_i    = bus.clear_err_i;
    assign bus_s.scaler_latch_i = bus.scaler_latch_i;
    assign bus_s.scaler_sel_i   = bus.scaler_sel_i;

    anita4_l2_trigger_receiver #(
        .NUM_CH(4), .MIN_WIDTH(MIN_W), .MAX_WIDTH(MAX_W),
        .COINC_WINDOW(3), .SCALER_WIDTH(16)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .bus(bus)
    );

    anita4_l2_trigger_receiver #(
        .NUM_CH(4), .MIN_WIDTH(MIN_W), .MAX_WIDTH(MAX_W),
        .COINC_WINDOW(3), .SCALER_WIDTH(4)
    ) dut_s (
        .clk_i(clk), .rst_n_i(rst_n), .bus(bus_s)
    );

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        ts_m <= rst_n ? ts_m + 32'd1 : 32'd0;
    end

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int c = 0; c < 4; c++) begin
                if (bus.l2_pulse_o[c]) begin
                    if (q.size() == 0)
                        check("l2_unexpected", cyc * 4 + c, 32'hffffffff);
                    else
                        check("l2_pulse", cyc * 4 + c, q.pop_front());
                end
            end
            if (bus.l3_o) begin
                l3_cnt++;
`ifdef TRIG_TIMESTAMP_EN
                check("l3_time", bus.l3_time_o, ts_m);
`else
                check("l3_time", bus.l3_time_o, 32'd0);
`endif
            end
        end
    end

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(int ch, bit v, int w);
        if (bus.trig_i[ch] && !v && w >= MIN_W && w <= MAX_W)
            q.push_back((cyc + 4) * 4 + ch);
        bus.trig_i[ch] = v;
    endtask

    task automatic pulse(int ch, int w, int gap);
        drive_bit(ch, 1'b1, w);
        step(w);
        drive_bit(ch, 1'b0, w);
        step(gap);
    endtask

    task automatic pat(int s0, int w0, int s2, int w2, int len);
        for (int k = 0; k < len; k++) begin
            drive_bit(0, (k >= s0) && (k < s0 + w0), w0);
            drive_bit(2, (k >= s2) && (k < s2 + w2), w2);
            step(1);
        end
    endtask

    task automatic latch();
        bus.scaler_latch_i = 1'b1;
        step(1);
        bus.scaler_latch_i = 1'b0;
    endtask

    task automatic clear_err();
        bus.clear_err_i = 1'b1;
        step(1);
        bus.clear_err_i = 1'b0;
    endtask

    initial begin
        bus.trig_i         = '0;
        bus.mask_i         = '0;
        bus.clear_err_i    = 1'b0;
        bus.scaler_latch_i = 1'b0;
        bus.scaler_sel_i   = 2'd0;
        #3;
        check("rst_l2", bus.l2_pulse_o, 0);
        check("rst_l3", bus.l3_o, 0);
        check("rst_err", bus.err_stuck_o, 0);
        check("rst_scaler", bus.scaler_o, 0);
        check("rst_l3_time", bus.l3_time_o, 0);
        step(2);
        rst_n = 1'b1;
        step(2);

        // basic accepted pulse and scaler readout
        pulse(0, 4, 6);
        latch();
        check("scaler_ch0", bus.scaler_o, 1);
        check("no_l3_single", l3_cnt, 0);

        // width qualification on ch2
        pulse(2, 1, 4);
        pulse(2, MIN_W, 4);
        pulse(2, MAX_W, 6);
        check("err_after_max", bus.err_stuck_o, 4'b0000);
        bus.trig_i[2] = 1'b1;
        step(7);
        bus.trig_i[2] = 1'b0;
        step(1);
        check("err_before_7", bus.err_stuck_o, 4'b0000);
        step(1);
        check("err_at_7", bus.err_stuck_o, 4'b0100);
        step(4);
        bus.trig_i[2] = 1'b1;
        step(8);
        clear_err();
        check("err_set_wins", bus.err_stuck_o, 4'b0100);
        step(2);
        bus.trig_i[2] = 1'b0;
        step(4);
        clear_err();
        check("err_cleared", bus.err_stuck_o, 4'b0000);

        // coincidence windows
        l3_base = l3_cnt;
        pat(0, 3, 2, 3, 8);
        step(8);
        check("l3_apart2", l3_cnt - l3_base, 1);
        l3_base = l3_cnt;
        pat(0, 3, 0, 3, 6);
        step(8);
        check("l3_apart0", l3_cnt - l3_base, 1);
        l3_base = l3_cnt;
        pat(0, 3, 3, 3, 9);
        step(8);
        check("l3_apart3", l3_cnt - l3_base, 0);
        l3_base = l3_cnt;
        pat(0, 3, 4, 3, 10);
        step(8);
        check("l3_apart4", l3_cnt - l3_base, 0);
        l3_base = l3_cnt;
        bus.mask_i = 4'b0100;
        pat(0, 3, 2, 3, 8);
        step(8);
        bus.mask_i = 4'b0000;
        check("l3_masked", l3_cnt - l3_base, 0);

        // scalers: latch coinciding with a pulse
        step(4);
        latch();
        for (int i = 0; i < 5; i++)
            pulse(1, 3, 2);
        drive_bit(1, 1'b1, 3);
        step(3);
        drive_bit(1, 1'b0, 3);
        step(4);
        latch();
        bus.scaler_sel_i = 2'd1;
        #1;
        check("scaler_coinc_latch", bus.scaler_o, 5);
        check("scaler_s_coinc_latch", bus_s.scaler_o, 5);
        bus.mask_i = 4'b1000;
        pulse(3, 3, 6);
        bus.mask_i = 4'b0000;
        latch();
        check("scaler_restart1", bus.scaler_o, 1);
        check("scaler_s_restart1", bus_s.scaler_o, 1);
        bus.scaler_sel_i = 2'd3;
        #1;
        check("scaler_masked", bus.scaler_o, 0);
        bus.scaler_sel_i = 2'd1;
        for (int i = 0; i < 19; i++)
            pulse(1, 2, 1);
        step(6);
        latch();
        check("scaler_19", bus.scaler_o, 19);
        check("scaler_s_sat", bus_s.scaler_o, 15);

        // reset during HIGH with an active window
        pulse(0, 3, 1);
        bus.trig_i[0] = 1'b1;
        step(5);
        rst_n = 1'b0;
        #1;
        check("mid_rst_l2", bus.l2_pulse_o, 0);
        check("mid_rst_l3", bus.l3_o, 0);
        check("mid_rst_err", bus.err_stuck_o, 0);
        check("mid_rst_scaler", bus.scaler_o, 0);
        check("mid_rst_l3_time", bus.l3_time_o, 0);
        step(1);
        rst_n = 1'b1;
        step(8);
        bus.trig_i[0] = 1'b0;
        check("post_rst_err_pre", bus.err_stuck_o, 4'b0000);
        step(1);
        check("post_rst_stuck", bus.err_stuck_o, 4'b0001);
        step(8);

        check("queue_empty", q.size(), 0);
        check("l3_total", l3_cnt, 2);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
